hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline controller for the EX-stage datapath of the 5-stage MIPS core. Generates the forwarding selects that drive the EX operand muxes, detects load-use and branch-compare hazards, and sequences multi-cycle multiply/divide operations by holding F/D/E and bubbling M until the operation completes. Forwarding and hazard detection are combinational. The multiply/divide occupancy tracker is a registered FSM with a down-counter.

## Interface
Parameters:
- MULT_CYCLES, 4, EX occupancy of a multiply in cycles after the start cycle (≥1)
- DIV_CYCLES, 32, EX occupancy of a divide in cycles after the start cycle (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  5  source registers of the D-stage instruction
- branchD  in  1  D-stage instruction is a branch that compares in D
- rsE, rtE  in  5  source registers of the E-stage instruction
- writeRegE, writeRegM, writeRegW  in  5  destination register per stage
- regWriteE, regWriteM, regWriteW  in  1  destination write enable per stage
- memToRegE, memToRegM  in  1  stage holds a load
- mdStartE  in  1  E-stage instruction is a multiply or divide
- mdOpE  in  1  0 = multiply, 1 = divide
- forward1E, forward2E  out  2  EX operand select: 00 register file, 01 resultW, 10 aluOutM
- forward1D, forward2D  out  1  D compare operand takes aluOutM
- stallF, stallD, stallE  out  1  hold the pipeline register of that stage
- flushE, flushM  out  1  insert a bubble into E or M
- mdBusy  out  1  mul/div FSM is in BUSY
- mdDone  out  1  one-cycle pulse: HI/LO result valid and written this cycle

## Operation
- Forwarding for forward1E/rsE; forward2E/rtE is identical:
  - Select 10 if regWriteM && writeRegM≠0 && writeRegM==rsE.
  - Otherwise select 01 if regWriteW && writeRegW≠0 && writeRegW==rsE.
  - Otherwise select 00. M always has priority over W.
- forward1D = regWriteM && writeRegM≠0 && writeRegM==rsD. forward2D is the same with rtD.
- lwStall = memToRegE && writeRegE≠0 && (writeRegE==rsD || writeRegE==rtD).
- brStall = branchD && (the E-stage hazard or the M-stage hazard):
  - E-stage: regWriteE && writeRegE≠0 && writeRegE∈{rsD,rtD}
  - M-stage: memToRegM && writeRegM≠0 && writeRegM∈{rsD,rtD}
- mdStall = (state==IDLE && mdStartE) || (state==BUSY && cnt≠0).
- Output equations:
  - stallF = stallD = lwStall | brStall | mdStall
  - stallE = flushM = mdStall
  - flushE = (lwStall | brStall) && !mdStall. E is frozen during mul/div, so it is never flushed then.
- FSM states: IDLE, BUSY.
  - IDLE & mdStartE → BUSY. cnt ← (mdOpE ? DIV_CYCLES : MULT_CYCLES) − 1.
  - BUSY & cnt≠0 → BUSY, cnt ← cnt − 1.
  - BUSY & cnt==0 → IDLE. mdDone=1 in this cycle.
  - mdStartE is ignored in BUSY. A back-to-back mul/div starts in the first IDLE cycle after completion.
- The mul/div unit captures operands in the start cycle. Forwarding outputs stay live during stalls but are not required to stay correct for the frozen instruction.
- cnt width is clog2(max(MULT_CYCLES, DIV_CYCLES)), minimum 1.

## Timing
- Reset (async, immediate):
  - state=IDLE, cnt=0.
  - While rst is high, all stall, flush, mdBusy and mdDone outputs are 0, and all forward outputs are 0.
  - Reset in the middle of BUSY aborts the operation with no mdDone.
- Forward and hazard outputs are combinational with zero latency.
- A mul/div with N cycles occupies E for N+1 cycles: the start cycle plus N BUSY cycles.
  - stallE is high for the first N of those cycles.
  - mdDone and stallE=0 occur together in the last cycle.
- mdBusy is high for exactly N cycles.
- A simultaneous lwStall and mdStall gives stallF/D=1, stallE=1, flushE=0, flushM=1.

## Test plan
- Forwarding, writeRegM=writeRegW=rsE=5, both regWrite=1 → forward1E=10. Then regWriteM=0 → forward1E=01. Then rsE=0 with regWrite set → 00.
- Load-use, memToRegE=1, writeRegE=rtD=8 → stallF=stallD=flushE=1, stallE=0 for one cycle. writeRegE=0 → no stall.
- Branch, branchD=1, regWriteE=1, writeRegE=rsD=3 → stall+flushE. Then memToRegM=1, writeRegM=3 → stall. regWriteM=1 with a non-load → forward1D=1, no stall.
- Multiply, MULT_CYCLES=4, mdStartE=1 at cycle 0 → stallE/flushM high in cycles 0–3, mdBusy high in 1–4, mdDone in cycle 4 only, IDLE in cycle 5. Divide → mdDone in cycle 32.
- Back-to-back, mdStartE held high across two multiplies → second start in cycle 5, second mdDone in cycle 9. Load-use during BUSY → flushE=0.
- Reset, rst pulsed in cycle 10 of a divide → outputs go to 0 immediately, no mdDone. After release, IDLE accepts a new start.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - EX-stage forwarding, hazard detection and mul/div occupancy control
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic [4:0] writeRegM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteE,
    input  logic       regWriteM,
    input  logic       regWriteW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       mdStartE,
    input  logic       mdOpE,
    output logic [1:0] forward1E,
    output logic [1:0] forward2E,
    output logic       forward1D,
    output logic       forward2D,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       flushM,
    output logic       mdBusy,
    output logic       mdDone
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          md_stall, md_done;
    logic          lw_stall, br_stall;

    // M-stage result is newer than W, so it wins when both match.
    function automatic logic [1:0] ex_fwd(input logic [4:0] src,
                                          input logic       rw_m,
                                          input logic [4:0] wr_m,
                                          input logic       rw_w,
                                          input logic [4:0] wr_w);
        if (rw_m && wr_m != 5'd0 && wr_m == src)
            return 2'b10;
        else if (rw_w && wr_w != 5'd0 && wr_w == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdStartE) begin
                    md_stall = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = mdOpE ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lw_stall = memToRegE && writeRegE != 5'd0 &&
                   (writeRegE == rsD || writeRegE == rtD);
        br_stall = branchD &&
                   ((regWriteE && writeRegE != 5'd0 && (writeRegE == rsD || writeRegE == rtD)) ||
                    (memToRegM && writeRegM != 5'd0 && (writeRegM == rsD || writeRegM == rtD)));
    end

    // Every output is forced quiet while reset is held.
    always_comb begin
        forward1E = 2'b00;
        forward2E = 2'b00;
        forward1D = 1'b0;
        forward2D = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        mdBusy    = 1'b0;
        mdDone    = 1'b0;
        if (!rst) begin
            forward1E = ex_fwd(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
            forward2E = ex_fwd(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
            forward1D = regWriteM && writeRegM != 5'd0 && writeRegM == rsD;
            forward2D = regWriteM && writeRegM != 5'd0 && writeRegM == rtD;
            stallF    = lw_stall | br_stall | md_stall;
            stallD    = lw_stall | br_stall | md_stall;
            stallE    = md_stall;
            flushM    = md_stall;
            flushE    = (lw_stall | br_stall) && !md_stall;
            mdBusy    = (state_q == BUSY);
            mdDone    = md_done;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int MC = 4;
    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       branchD, regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       mdStartE, mdOpE;
    logic [1:0] forward1E, forward2E;
    logic       forward1D, forward2D, stallF, stallD, stallE, flushE, flushM, mdBusy, mdDone;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .mdStartE(mdStartE), .mdOpE(mdOpE),
        .forward1E(forward1E), .forward2E(forward2E),
        .forward1D(forward1D), .forward2D(forward2D),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .mdBusy(mdBusy), .mdDone(mdDone)
    );

    // {f1E, f2E, f1D, f2D, stallF, stallD, stallE, flushE, flushM, busy, done}
    logic [12:0] outv;
    assign outv = {forward1E, forward2E, forward1D, forward2D, stallF, stallD,
                   stallE, flushE, flushM, mdBusy, mdDone};

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    typedef struct {
        string      nm;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       br, rw_e, rw_m, rw_w, ld_e, ld_m;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input string nm,
                                input logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w,
                                input logic br, rw_e, rw_m, rw_w, ld_e, ld_m,
                                input logic [12:0] exp);
        vec_t v;
        v.nm = nm; v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
        v.wr_e = wr_e; v.wr_m = wr_m; v.wr_w = wr_w;
        v.br = br; v.rw_e = rw_e; v.rw_m = rw_m; v.rw_w = rw_w; v.ld_e = ld_e; v.ld_m = ld_m;
        v.exp = exp;
        return v;
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
        branchD = 0; regWriteE = 0; regWriteM = 0; regWriteW = 0;
        memToRegE = 0; memToRegM = 0; mdStartE = 0; mdOpE = 0;
    endtask

    task automatic apply(input vec_t v);
        rsD = v.rs_d; rtD = v.rt_d; rsE = v.rs_e; rtE = v.rt_e;
        writeRegE = v.wr_e; writeRegM = v.wr_m; writeRegW = v.wr_w;
        branchD = v.br; regWriteE = v.rw_e; regWriteM = v.rw_m; regWriteW = v.rw_w;
        memToRegE = v.ld_e; memToRegM = v.ld_m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an operation is tracked by its cycle index p within
    // its N+1 cycle occupancy window (p = 0 is the start cycle).
    int md_p = -1;
    int md_n = 0;

    function automatic int eff_phase();
        if (md_p >= 0) return md_p;
        return mdStartE ? 0 : -1;
    endfunction

    function automatic int eff_len();
        if (md_p >= 0) return md_n;
        return mdOpE ? DC : MC;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (regWriteM && writeRegM != 0 && writeRegM == src) return 2'd2;
        if (regWriteW && writeRegW != 0 && writeRegW == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [12:0] model_out();
        logic lw, br, hz, mds, busy, done;
        int   p, n;
        if (rst) return 13'd0;
        p    = eff_phase();
        n    = eff_len();
        lw   = memToRegE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD);
        br   = branchD && ((regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD)) ||
                           (memToRegM && writeRegM != 0 && (writeRegM == rsD || writeRegM == rtD)));
        hz   = lw || br;
        mds  = (p >= 0) && (p < n);
        busy = (p >= 1);
        done = (p >= 1) && (p == n);
        return {m_fwd(rsE), m_fwd(rtE),
                regWriteM && writeRegM != 0 && writeRegM == rsD,
                regWriteM && writeRegM != 0 && writeRegM == rtD,
                hz || mds, hz || mds, mds, hz && !mds, mds, busy, done};
    endfunction

    task automatic model_advance();
        int p, n;
        p = eff_phase();
        n = eff_len();
        if (rst || p < 0 || p == n) begin
            md_p = -1;
        end else begin
            md_p = p + 1;
            md_n = n;
        end
    endtask

    initial begin
        tbl[0]  = mk("fwd_m_pri",   0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 0, 0, 13'b10_00_0_0_0_0_0_0_0_0_0);
        tbl[1]  = mk("fwd_w",       0, 0, 5, 0, 0, 5, 5, 0, 0, 0, 1, 0, 0, 13'b01_00_0_0_0_0_0_0_0_0_0);
        tbl[2]  = mk("fwd_r0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 13'b00_00_0_0_0_0_0_0_0_0_0);
        tbl[3]  = mk("fwd2_m",      0, 0, 0, 7, 0, 7, 7, 0, 0, 1, 1, 0, 0, 13'b00_10_0_0_0_0_0_0_0_0_0);
        tbl[4]  = mk("load_use",    0, 8, 0, 0, 8, 0, 0, 0, 1, 0, 0, 1, 0, 13'b00_00_0_0_1_1_0_1_0_0_0);
        tbl[5]  = mk("load_r0",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 13'b00_00_0_0_0_0_0_0_0_0_0);
        tbl[6]  = mk("br_e",        3, 0, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 13'b00_00_0_0_1_1_0_1_0_0_0);
        tbl[7]  = mk("br_m_load",   3, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 1, 13'b00_00_1_0_1_1_0_1_0_0_0);
        tbl[8]  = mk("br_m_fwd",    3, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 0, 13'b00_00_1_0_0_0_0_0_0_0_0);
        tbl[9]  = mk("fwd2_d",      0, 9, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0, 13'b00_00_0_1_0_0_0_0_0_0_0);
        tbl[10] = mk("br_e_r0",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 13'b00_00_0_0_0_0_0_0_0_0_0);
        tbl[11] = mk("br_e_nowr",   3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 13'b00_00_0_0_0_0_0_0_0_0_0);
        tbl[12] = mk("fwd_mix",     0, 0, 6, 4, 0, 4, 6, 0, 0, 1, 1, 0, 0, 13'b01_10_0_0_0_0_0_0_0_0_0);

        // Reset with hazard-producing inputs: every output must be quiet.
        clear_inputs();
        rst = 1'b1;
        apply(tbl[4]);
        writeRegM = 5; regWriteM = 1; rsE = 5; rsD = 5; mdStartE = 1;
        #2 check("reset_outs", outv, 13'd0);
        tick();
        rst = 1'b0;
        clear_inputs();

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #2 check(tbl[i].nm, outv, tbl[i].exp);
        end
        clear_inputs();
        tick();

        // Multiply with a load-use hazard landing in a BUSY cycle.
        mdStartE = 1; mdOpE = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) mdStartE = 0;
            if (c == 2) begin memToRegE = 1; writeRegE = 8; rtD = 8; end
            if (c == 3) clear_inputs();
            #2;
            check($sformatf("mul_c%0d", c), {9'd0, stallE, flushM, mdBusy, mdDone},
                  {9'd0, c <= 3, c <= 3, c >= 1 && c <= 4, c == 4});
            if (c == 2) check("lw_in_busy", {11'd0, stallF, flushE}, 13'b10);
            tick();
        end

        // Back-to-back multiplies with start held high throughout.
        mdStartE = 1; mdOpE = 0;
        for (int c = 0; c <= 9; c++) begin
            #2;
            check($sformatf("b2b_c%0d", c), {10'd0, stallE, mdBusy, mdDone},
                  {10'd0, (c <= 3) || (c >= 5 && c <= 8),
                   (c >= 1 && c <= 4) || (c >= 6), c == 4 || c == 9});
            tick();
        end
        mdStartE = 0;
        #2 check("b2b_idle", outv, 13'd0);
        tick();

        // Divide.
        mdStartE = 1; mdOpE = 1;
        for (int c = 0; c <= 33; c++) begin
            if (c == 1) mdStartE = 0;
            #2;
            if (c == 0 || c >= 31)
                check($sformatf("div_c%0d", c), {10'd0, stallE, mdBusy, mdDone},
                      {10'd0, c <= 31, c >= 1 && c <= 32, c == 32});
            tick();
        end

        // Reset in the middle of a divide.
        mdStartE = 1; mdOpE = 1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) mdStartE = 0;
            if (c == 10) begin
                writeRegM = 5; regWriteM = 1; rsE = 5; rsD = 5;
                #2 rst = 1'b1;
                #1 check("rst_mid_div", outv, 13'd0);
            end else begin
                tick();
            end
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        for (int c = 0; c < 30; c++) begin
            #2 check($sformatf("post_rst_c%0d", c), outv, 13'd0);
            tick();
        end
        mdStartE = 1; mdOpE = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) mdStartE = 0;
            #2;
            check($sformatf("rst_mul_c%0d", c), {10'd0, stallE, mdBusy, mdDone},
                  {10'd0, c <= 3, c >= 1 && c <= 4, c == 4});
            tick();
        end

        // Randomized traffic against the reference model.
        md_p = -1;
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            rsE       = 5'($urandom_range(0, 3));
            rtE       = 5'($urandom_range(0, 3));
            writeRegE = 5'($urandom_range(0, 3));
            writeRegM = 5'($urandom_range(0, 3));
            writeRegW = 5'($urandom_range(0, 3));
            branchD   = 1'($urandom_range(0, 1));
            regWriteE = 1'($urandom_range(0, 1));
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            memToRegE = 1'($urandom_range(0, 1));
            memToRegM = 1'($urandom_range(0, 1));
            mdStartE  = ($urandom_range(0, 19) == 0);
            mdOpE     = ($urandom_range(0, 3) == 0);
            #2 check($sformatf("rand_%0d", k), outv, model_out());
            model_advance();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
